// File: rtl/core_inst_seq_if.sv
// Control/bus bundle between the tile controller and core_inst_seq.
// master = controller side (drives start/bases), slave = sequencer side.
interface core_inst_seq_if #(
    parameter int addr_bw = 11,
    parameter int len_bw  = 6
) ();
    logic               start;
    logic [len_bw-1:0]  n_act;
    logic [addr_bw-1:0] w_base;
    logic [addr_bw-1:0] x_base;
    logic [addr_bw-1:0] p_base;
    logic               ofifo_valid;
    logic [33:0]        inst;
    logic               busy;
    logic               done;
    logic               timeout;

    modport master (
        output start, n_act, w_base, x_base, p_base, ofifo_valid,
        input  inst, busy, done, timeout
    );

    modport slave (
        input  start, n_act, w_base, x_base, p_base, ofifo_valid,
        output inst, busy, done, timeout
    );
endinterface

// File: rtl/core_inst_seq.sv
// Tile instruction sequencer: weight fetch, kernel load, activation fetch, execute, psum drain.
// Optional drain watchdog enabled by defining CORE_INST_SEQ_TIMEOUT_EN.
module core_inst_seq #(
    parameter int row     = 8,
    parameter int col     = 8,
    parameter int addr_bw = 11,
    parameter int len_bw  = 6,
    parameter int TIMEOUT = 255
) (
    input logic            clk,
    input logic            reset,
    core_inst_seq_if.slave bus
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_W_RD   = 3'd1;
    localparam logic [2:0] S_W_LOAD = 3'd2;
    localparam logic [2:0] S_A_RD   = 3'd3;
    localparam logic [2:0] S_EXEC   = 3'd4;
    localparam logic [2:0] S_DRAIN  = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

    localparam logic [33:0] INST_IDLE = 34'h1_800C_0000;
    localparam int CNT_W = ($clog2(row + col) > len_bw) ? $clog2(row + col) : len_bw;

    logic [2:0]         state, next;
    logic [CNT_W-1:0]   cnt, term, last_n;
    logic               adv, at_end, rd_d, x_rd, p_wr, wd_fire;
    logic [len_bw-1:0]  n_lat;
    logic [addr_bw-1:0] w_lat, x_lat, p_lat;

    assign last_n = CNT_W'(n_lat) - CNT_W'(1);
    assign x_rd   = (state == S_W_RD) || (state == S_A_RD);
    assign p_wr   = (state == S_DRAIN) && bus.ofifo_valid;

    always_comb begin
        term = '0;
        adv  = 1'b1;
        next = S_IDLE;
        case (state)
            S_W_RD:   begin term = CNT_W'(row - 1);       next = S_W_LOAD; end
            S_W_LOAD: begin term = CNT_W'(row + col - 1); next = S_A_RD;   end
            S_A_RD:   begin term = last_n;                next = S_EXEC;   end
            S_EXEC:   begin term = last_n;                next = S_DRAIN;  end
            S_DRAIN:  begin term = last_n; adv = p_wr;    next = S_DONE;   end
            default:  ;
        endcase
    end
    assign at_end = adv && (cnt == term);

`ifdef CORE_INST_SEQ_TIMEOUT_EN
    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [WD_W-1:0] wd;
    logic            to_flag;

    // Counts consecutive empty DRAIN cycles; fires on the TIMEOUT-th one.
    assign wd_fire = (state == S_DRAIN) && !bus.ofifo_valid && (wd == WD_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            wd      <= '0;
            to_flag <= 1'b0;
        end else begin
            if ((state != S_DRAIN) || p_wr || wd_fire) wd <= '0;
            else                                       wd <= wd + WD_W'(1);
            if (wd_fire) to_flag <= 1'b1;
        end
    end
    assign bus.timeout = to_flag;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT;
    assign wd_fire     = 1'b0;
    assign bus.timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            rd_d  <= 1'b0;
            n_lat <= '0;
            w_lat <= '0;
            x_lat <= '0;
            p_lat <= '0;
        end else begin
            rd_d <= x_rd;
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (bus.start && (bus.n_act != '0)) begin
                        state <= S_W_RD;
                        n_lat <= bus.n_act;
                        w_lat <= bus.w_base;
                        x_lat <= bus.x_base;
                        p_lat <= bus.p_base;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                end
                S_W_RD, S_W_LOAD, S_A_RD, S_EXEC, S_DRAIN: begin
                    if (at_end || wd_fire) begin
                        state <= next;
                        cnt   <= '0;
                    end else if (adv) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Field map: [33] acc, [32] CEN_p, [31] WEN_p, [30:20] A_p, [19] CEN_x, [18] WEN_x,
    // [17:7] A_x, [6] ofifo_rd, [5] ififo_wr, [4] ififo_rd, [3] l0_rd, [2] l0_wr, [1] execute, [0] load
    always_comb begin
        inst_dec: begin
            bus.inst = INST_IDLE;
            case (state)
                S_W_RD: begin
                    bus.inst[19]   = 1'b0;
                    bus.inst[17:7] = 11'(w_lat + addr_bw'(cnt));
                end
                S_W_LOAD: begin
                    bus.inst[0] = 1'b1;
                    bus.inst[3] = (cnt < CNT_W'(row));
                end
                S_A_RD: begin
                    bus.inst[19]   = 1'b0;
                    bus.inst[17:7] = 11'(x_lat + addr_bw'(cnt));
                end
                S_EXEC: begin
                    bus.inst[3] = 1'b1;
                    bus.inst[1] = 1'b1;
                end
                S_DRAIN: begin
                    if (p_wr) begin
                        bus.inst[32]    = 1'b0;
                        bus.inst[31]    = 1'b0;
                        bus.inst[30:20] = 11'(p_lat + addr_bw'(cnt));
                        bus.inst[6]     = 1'b1;
                    end
                end
                default: ;
            endcase
            bus.inst[2] = rd_d;
        end
    end

    assign bus.busy = (state != S_IDLE);
    assign bus.done = (state == S_DONE);
endmodule

// File: tb/tb_core_inst_seq.sv
// Self-checking bench for core_inst_seq: vector table of tiles, cycle-accurate control model,
// address scoreboard, plus reset / ignored-start / watchdog sequences.
module tb_core_inst_seq;
    localparam logic [33:0] IDLE = 34'h1_800C_0000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;
    bit   mon_en = 1'b0;
    logic [10:0] xq[$];
    logic [10:0] pq[$];

    always #5 clk = ~clk;

    core_inst_seq_if #(.addr_bw(11), .len_bw(6)) bus ();

    core_inst_seq #(
        .row(8), .col(8), .addr_bw(11), .len_bw(6), .TIMEOUT(10)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Address scoreboard: expected xmem/pmem addresses queued when a tile is launched.
    always @(negedge clk) begin
        #2;
        if (mon_en) begin
            if (bus.inst[19] == 1'b0) begin
                if (xq.size() == 0) check("xmem_unexpected_read", 64'(bus.inst[17:7]), 64'hFFFF);
                else check("xmem_addr", 64'(bus.inst[17:7]), 64'(xq.pop_front()));
            end
            if (bus.inst[32] == 1'b0) begin
                check("pmem_wr_ctrl", {61'd0, bus.inst[31], bus.inst[6], bus.ofifo_valid}, 64'd3);
                if (pq.size() == 0) check("pmem_unexpected_write", 64'(bus.inst[30:20]), 64'hFFFF);
                else check("pmem_addr", 64'(bus.inst[30:20]), 64'(pq.pop_front()));
            end
        end
    end

    typedef struct {
        logic [5:0]  n;
        logic [10:0] w, x, p;
        logic [15:0] pat;
        bit          poke;
        int          exp_done;
    } vec_t;
    vec_t vecs[6];

    task automatic launch(input logic [5:0] n, input logic [10:0] w, x, p);
        @(negedge clk);
        bus.start = 1'b1;
        bus.n_act = n;
        bus.w_base = w;
        bus.x_base = x;
        bus.p_base = p;
        bus.ofifo_valid = 1'b0;
    endtask

    task automatic run_tile(input int vi);
        vec_t v;
        int n, d, mdone, writes, obs, k;
        logic [33:0] e, m;
        logic vbit, wr;
        v = vecs[vi];
        n = int'(v.n);
        d = 25 + 2 * n;
        mdone = 1 << 30;
        writes = 0;
        obs = 0;
        for (int j = 0; j < 8; j++) xq.push_back(v.w + 11'(j));
        for (int j = 0; j < n; j++) begin
            xq.push_back(v.x + 11'(j));
            pq.push_back(v.p + 11'(j));
        end
        launch(v.n, v.w, v.x, v.p);
        k = 1;
        while (k <= mdone && k < 1000) begin
            @(negedge clk);
            bus.start = v.poke && (k == 30);
            if (bus.start) begin
                bus.n_act = 6'd2;
                bus.w_base = 11'd999;
                bus.x_base = 11'd555;
                bus.p_base = 11'd333;
            end
            if (k >= d) vbit = v.pat[(k - d) % 16];
            else        vbit = 1'($urandom_range(0, 1));
            bus.ofifo_valid = vbit;
            #1;
            e = IDLE;
            m = '1;
            wr = (k >= d) && (writes < n) && vbit;
            if (k >= 1 && k <= 8) begin e[19] = 1'b0; m[17:7] = '0; end
            if (k >= 25 && k <= 24 + n) begin e[19] = 1'b0; m[17:7] = '0; end
            if ((k >= 2 && k <= 9) || (k >= 26 && k <= 25 + n)) e[2] = 1'b1;
            if (k >= 9 && k <= 24) e[0] = 1'b1;
            if (k >= 9 && k <= 16) e[3] = 1'b1;
            if (k >= 25 + n && k <= 24 + 2 * n) begin e[3] = 1'b1; e[1] = 1'b1; end
            if (wr) begin e[32] = 1'b0; e[31] = 1'b0; e[6] = 1'b1; m[30:20] = '0; end
            check($sformatf("tile%0d_cycle%0d", vi, k),
                  {27'd0, bus.inst & m, bus.busy, bus.done, bus.timeout},
                  {27'd0, e & m, 1'b1, (k == mdone), 1'b0});
            if (bus.done && obs == 0) obs = k;
            if (wr) begin
                writes++;
                if (writes == n) mdone = k + 1;
            end
            k++;
        end
        check($sformatf("tile%0d_bound", vi), 64'(k < 1000), 64'd1);
        check($sformatf("tile%0d_done_cycle", vi), 64'(obs), 64'(v.exp_done));
        #2;
        check($sformatf("tile%0d_xq_empty", vi), 64'(xq.size()), 64'd0);
        check($sformatf("tile%0d_pq_empty", vi), 64'(pq.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        bus.start = 1'b0;
        bus.n_act = '0;
        bus.w_base = '0;
        bus.x_base = '0;
        bus.p_base = '0;
        bus.ofifo_valid = 1'b0;

        vecs[0] = '{n: 6'd4,  w: 11'd0,    x: 11'd16,   p: 11'd100,  pat: 16'hFFFF, poke: 1'b1, exp_done: 37};
        vecs[1] = '{n: 6'd4,  w: 11'd0,    x: 11'd16,   p: 11'd100,  pat: 16'hFFD9, poke: 1'b0, exp_done: 40};
        vecs[2] = '{n: 6'd4,  w: 11'd2044, x: 11'd2046, p: 11'd2046, pat: 16'hFFFF, poke: 1'b0, exp_done: 37};
        vecs[3] = '{n: 6'd1,  w: 11'd5,    x: 11'd7,    p: 11'd9,    pat: 16'hFFFF, poke: 1'b0, exp_done: 28};
        vecs[4] = '{n: 6'd5,  w: 11'd300,  x: 11'd400,  p: 11'd500,  pat: 16'h5555, poke: 1'b0, exp_done: 44};
        vecs[5] = '{n: 6'd63, w: 11'd100,  x: 11'd200,  p: 11'd2000, pat: 16'hAAAA, poke: 1'b0, exp_done: 277};

        repeat (3) @(negedge clk);
        #1;
        check("reset_state", {27'd0, bus.inst, bus.busy, bus.done, bus.timeout}, {27'd0, IDLE, 3'b000});
        @(negedge clk);
        reset = 1'b0;
        mon_en = 1'b1;

        // start with n_act=0 must be ignored
        launch(6'd0, 11'd10, 11'd20, 11'd30);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            #1;
            check($sformatf("zero_start_%0d", i), {28'd0, bus.inst, bus.busy, bus.done}, {28'd0, IDLE, 2'b00});
        end

        // back-to-back tiles: each start lands in the IDLE cycle right after DONE
        for (int i = 0; i < 6; i++) run_tile(i);

        // reset in the middle of A_RD: reads 0..7 and x 16,17 happen, then nothing more
        for (int j = 0; j < 8; j++) xq.push_back(11'(j));
        xq.push_back(11'd16);
        xq.push_back(11'd17);
        launch(6'd4, 11'd0, 11'd16, 11'd100);
        for (int k = 1; k <= 26; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            bus.ofifo_valid = 1'b1;
        end
        #1;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset_mid_inst", {28'd0, bus.inst, bus.busy, bus.done}, {28'd0, IDLE, 2'b00});
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check($sformatf("reset_mid_idle_%0d", i), {28'd0, bus.inst, bus.busy, bus.done}, {28'd0, IDLE, 2'b00});
        end
        #2;
        check("reset_mid_xq_empty", 64'(xq.size()), 64'd0);

`ifdef CORE_INST_SEQ_TIMEOUT_EN
        begin
            int obs;
            obs = 0;
            for (int j = 0; j < 8; j++) xq.push_back(11'(j));
            xq.push_back(11'd16);
            xq.push_back(11'd17);
            launch(6'd2, 11'd0, 11'd16, 11'd100);
            for (int k = 1; k <= 45; k++) begin
                @(negedge clk);
                bus.start = 1'b0;
                bus.ofifo_valid = (k >= 29) ? 1'b0 : 1'($urandom_range(0, 1));
                #1;
                if (bus.done && obs == 0) obs = k;
                if (k == 39) check("wd_timeout_at_done", 64'(bus.timeout), 64'd1);
            end
            check("wd_done_cycle", 64'(obs), 64'd39);
            check("wd_timeout_sticky", {62'd0, bus.timeout, bus.busy}, 64'd2);
            check("wd_no_pmem_left", 64'(pq.size()), 64'd0);
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            #1;
            check("wd_timeout_cleared", 64'(bus.timeout), 64'd0);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/core_inst_seq.md
Name: core_inst_seq

Overview:
- Instruction sequencer for the 8x8 core: generates the full 34-bit `inst` word each cycle to run one tile end to end: weight fetch, kernel load, activation fetch, execute, psum drain into PMEM.
- Sits between the testbench/top control and `core`. The bench supplies only `start`, base addresses and vector count; this block owns every xmem/pmem/L0/OFIFO/array control bit.

Parameters:
- row, 8, PE array rows; number of weight words fetched per tile
- col, 8, PE array columns; kernel-load propagation length
- addr_bw, 11, SRAM address width for xmem and pmem
- len_bw, 6, width of the activation-count input
- TIMEOUT, 255, drain watchdog limit in cycles (used only with the optional feature)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- start  in  1  one-cycle tile start request
- n_act  in  len_bw  activation vectors (= psum results) in this tile
- w_base  in  addr_bw  xmem base address of the weights
- x_base  in  addr_bw  xmem base address of the activations
- p_base  in  addr_bw  pmem base address for results
- ofifo_valid  in  1  OFIFO holds at least one complete psum row
- inst  out  34  core instruction word; field map is the core's standard map
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at tile completion
- timeout  out  1  sticky error flag (optional feature only; otherwise tied 0)

Behaviour:
- Reset:
  - state=IDLE, counters 0, rd_d=0, done=0, busy=0.
  - inst=34'h1_800C_0000: CEN/WEN for both SRAMs high (inactive), all other bits 0.
- Idle value: inst holds the same idle value whenever no field is active. acc (inst[33]) is always 0. Unused address fields hold 0.
- Output timing:
  - inst is decoded from registered state/counter/rd_d.
  - The only combinational input paths are ofifo_valid -> ofifo_rd and pmem CEN/WEN in DRAIN.
- Start:
  - Sampled only in IDLE. n_act, w_base, x_base and p_base are latched on the accepted start.
  - start with n_act=0 is ignored (stay IDLE, no done). start while busy is ignored.
- W_RD, row cycles, cnt 0..row-1: CEN_x=0, WEN_x=1, A_x=w_base+cnt.
- rd_d: register set when an xmem read is issued, cleared otherwise. l0_wr=rd_d, so the L0 write lags each read by 1 cycle (SRAM read latency 1), independent of state.
- W_LOAD, row+col cycles: load=1 in all of them; l0_rd=1 for the first row cycles only.
- A_RD, n_act cycles: xmem read of x_base+cnt; l0_wr lags as above.
- EXEC, n_act cycles: l0_rd=1, execute=1.
- DRAIN:
  - Each cycle with ofifo_valid=1: ofifo_rd=1, CEN_p=0, WEN_p=0, A_p=p_base+cnt, cnt++.
  - Cycles with ofifo_valid=0: idle value; stay in DRAIN.
  - After write n_act-1: go to DONE.
  - OFIFO is show-ahead: data is valid in the same cycle as ofifo_rd.
- DONE: done=1 for 1 cycle, then IDLE. A start in the cycle after DONE is accepted.
- Transitions: IDLE->W_RD->W_LOAD->A_RD->EXEC->DRAIN->DONE->IDLE. Each phase exits when cnt reaches its terminal count; cnt resets to 0 on every transition.
- Address arithmetic: modulo 2^addr_bw; base+cnt wraps silently past 2047 to 0.
- Reset mid-operation: returns to IDLE with the idle inst in the next cycle; a pending rd_d is discarded (no trailing l0_wr); no done pulse.

Optional Feature:
- Macro: CORE_INST_SEQ_TIMEOUT_EN.
- Defined:
  - A watchdog counts consecutive DRAIN cycles with ofifo_valid=0 and resets on each write.
  - When it reaches TIMEOUT: set timeout=1 (sticky until reset), go to DONE, pulse done. Remaining results are not written.
- Undefined: no watchdog; DRAIN waits indefinitely; timeout tied 0.

Test Plan:
- Basic tile: reset; start, n_act=4, w_base=0, x_base=16, p_base=100, ofifo_valid=1 -> xmem reads 0..7 in cycles 1-8, l0_wr in cycles 2-9; load for 16 cycles; reads 16..19; 4 execute cycles; pmem writes 100..103; done exactly 1 cycle after the last write; total 38 cycles start-to-done.
- Stalled drain: same tile, ofifo_valid toggles 1,0,0,1,1,0,1 -> pmem writes only in valid cycles, addresses 100..103 contiguous, ofifo_rd never asserted when valid=0.
- Wrap: w_base=2044 -> xmem addresses 2044,2045,2046,2047,0,1,2,3.
- Ignored starts: start with n_act=0 -> stays IDLE, busy=0; start pulses during EXEC -> no effect, single done.
- Reset mid-A_RD: assert reset for 1 cycle -> next cycle inst=34'h1_800C_0000, l0_wr=0, busy=0, no done.
- With CORE_INST_SEQ_TIMEOUT_EN, TIMEOUT=10, ofifo_valid held 0 in DRAIN -> timeout=1 and done pulse 10 cycles after entering DRAIN, 0 pmem writes.
